// File: rtl/wa_write_buffer_pkg.sv
// Shared types for the write-side buffer: FIFO entry layout, drain FSM states
// and the drop-counter saturation value.
package lib;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wa_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wa_buf_state_e;

  localparam logic [7:0] WA_DROP_MAX = 8'hFF;

endpackage

// File: rtl/wa_write_buffer_fifo.sv
// Synchronous FIFO with a combinational head read, so that the consumer can
// capture the head in the same edge it pops. Level, full and empty are registered.
module sync_fifo
  import lib::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = wa_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_level;
  logic            r_full;
  logic            r_empty;
  logic [PW:0]     w_level_next;

  always_comb begin
    w_level_next = r_level;
    case ({push, pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // Storage has no reset; zeroing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/wa_write_buffer.sv
// Write buffer between SIF and target: FIFO capture, req/ack drain FSM, overflow flag.
// Optional 8-bit saturating drop counter port enabled by WA_BUF_DROP_CNT_EN.
module wa_write_buffer
  import lib::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wa_wr_s,
  input  logic [AW-1:0]          wa_addr,
  input  logic [DW-1:0]          wa_data_wr,
  output logic                   tg_req,
  output logic [AW-1:0]          tg_addr,
  output logic [DW-1:0]          tg_data,
  input  logic                   tg_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf,
`ifdef WA_BUF_DROP_CNT_EN
  input  logic                   ovf_clr,
  output logic [7:0]             drop_cnt
`else
  input  logic                   ovf_clr
`endif
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        w_wr_entry;
  entry_t        w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  wa_buf_state_e r_state;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_ovf;

  assign w_wr_entry = '{addr: wa_addr, data: wa_data_wr};

  // tg_ack -> pop is the only combinational path through the block.
  assign w_pop  = !w_empty && ((r_state == IDLE) || tg_ack);
  assign w_push = wa_wr_s && (!w_full || w_pop);
  assign w_drop = wa_wr_s && w_full && !w_pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr_entry),
    .rdata (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_addr  <= w_head.addr;
            r_data  <= w_head.data;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (tg_ack) begin
            if (w_pop) begin
              r_addr <= w_head.addr;
              r_data <= w_head.data;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

`ifdef WA_BUF_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != WA_DROP_MAX)  r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign tg_req  = r_req;
  assign tg_addr = r_addr;
  assign tg_data = r_data;
  assign full    = w_full;
  assign empty   = w_empty;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_wa_write_buffer.sv
// Self-checking bench for wa_write_buffer: directed scenarios plus random traffic
// against a queue-based reference model. Drop counter checks need WA_BUF_DROP_CNT_EN.
module tb_wa_write_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wa_wr_s = 1'b0;
  logic [15:0] wa_addr = '0;
  logic [15:0] wa_data_wr = '0;
  logic        tg_ack = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        tg_req;
  logic [15:0] tg_addr;
  logic [15:0] tg_data;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        ovf;
`ifdef WA_BUF_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  wa_write_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wa_wr_s    (wa_wr_s),
    .wa_addr    (wa_addr),
    .wa_data_wr (wa_data_wr),
    .tg_req     (tg_req),
    .tg_addr    (tg_addr),
    .tg_data    (tg_data),
    .tg_ack     (tg_ack),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
`ifdef WA_BUF_DROP_CNT_EN
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
`else
    .ovf_clr    (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending entries, the entry presented to the target, overflow state.
  logic [31:0] m_q[$];
  bit          m_req;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  bit          m_ovf;
  int          m_drops;

  bit          rec = 1'b0;
  logic [31:0] xfer_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_edge(bit wr, logic [15:0] a, logic [15:0] d, bit ack, bit clr);
    int          sz;
    bit          pop;
    bit          drop;
    logic [31:0] h;
    sz   = m_q.size();
    pop  = (sz != 0) && (!m_req || ack);
    drop = wr && (sz == DEPTH) && !pop;
    if (pop) begin
      h      = m_q.pop_front();
      m_addr = h[31:16];
      m_data = h[15:0];
      m_req  = 1'b1;
    end else if (m_req && ack) begin
      m_req = 1'b0;
    end
    if (wr && !drop) m_q.push_back({a, d});
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".req"},   32'(tg_req),  32'(m_req));
    chk({tag, ".addr"},  32'(tg_addr), 32'(m_addr));
    chk({tag, ".data"},  32'(tg_data), 32'(m_data));
    chk({tag, ".level"}, 32'(level),   32'(m_q.size()));
    chk({tag, ".full"},  32'(full),    32'(m_q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),   32'(m_q.size() == 0));
    chk({tag, ".ovf"},   32'(ovf),     32'(m_ovf));
`ifdef WA_BUF_DROP_CNT_EN
    chk({tag, ".drop"},  32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic step(bit wr, logic [15:0] a, logic [15:0] d, bit ack, bit clr);
    @(negedge clk);
    wa_wr_s    = wr;
    wa_addr    = a;
    wa_data_wr = d;
    tg_ack     = ack;
    ovf_clr    = clr;
    #1;
    if (tg_req && tg_ack) begin
      $display("xfer addr=%h data=%h level=%0d", tg_addr, tg_data, level);
      if (rec) xfer_q.push_back({tg_addr, tg_data});
    end
    @(posedge clk);
    model_edge(wr, a, d, ack, clr);
    #1;
    check_all("model");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    bit          ack;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(tg_req),  32'd0);
    chk("rst_addr",  32'(tg_addr), 32'd0);
    chk("rst_data",  32'(tg_data), 32'd0);
    chk("rst_level", 32'(level),   32'd0);
    chk("rst_empty", 32'(empty),   32'd1);
    chk("rst_full",  32'(full),    32'd0);
    chk("rst_ovf",   32'(ovf),     32'd0);
`ifdef WA_BUF_DROP_CNT_EN
    chk("rst_drop",  32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single write with tg_ack tied high
    step(1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0);
    chk("single_lvl1",  32'(level),  32'd1);
    chk("single_noreq", 32'(tg_req), 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("single_req",   32'(tg_req),  32'd1);
    chk("single_addr",  32'(tg_addr), 32'h0010);
    chk("single_data",  32'(tg_data), 32'hBEEF);
    chk("single_lvl0",  32'(level),   32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("single_reqlo", 32'(tg_req),  32'd0);
    chk("single_lvlend", 32'(level),  32'd0);

    // Burst of 8 with backpressure, then fill and overflow
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(i) + 16'h0100, 1'b0, 1'b0);
    chk("burst_lvl7",  32'(level),   32'd7);
    chk("burst_full0", 32'(full),    32'd0);
    chk("burst_req",   32'(tg_req),  32'd1);
    chk("burst_addr0", 32'(tg_addr), 32'h0000);
    chk("burst_data0", 32'(tg_data), 32'h0100);
    step(1'b1, 16'h0008, 16'h0108, 1'b0, 1'b0);
    chk("burst9_lvl",  32'(level), 32'd8);
    chk("burst9_full", 32'(full),  32'd1);
    chk("burst9_ovf",  32'(ovf),   32'd0);
    step(1'b1, 16'h0009, 16'h0109, 1'b0, 1'b0);
    chk("burst10_ovf", 32'(ovf),   32'd1);
    chk("burst10_lvl", 32'(level), 32'd8);
`ifdef WA_BUF_DROP_CNT_EN
    chk("burst10_drop", 32'(drop_cnt), 32'd1);
`endif

    // Full with simultaneous pop: write accepted, level unchanged
    step(1'b1, 16'h000A, 16'h010A, 1'b1, 1'b0);
    chk("fullpop_lvl",  32'(level),   32'd8);
    chk("fullpop_ovf",  32'(ovf),     32'd1);
    chk("fullpop_addr", 32'(tg_addr), 32'h0001);

    // ovf clear racing a drop, then clear alone
    step(1'b1, 16'h000B, 16'h010B, 1'b0, 1'b1);
    chk("race_ovf", 32'(ovf), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf",  32'(ovf), 32'd0);
`ifdef WA_BUF_DROP_CNT_EN
    chk("clr_drop_kept", 32'(drop_cnt), 32'd2);
`endif

    // Drain everything
    for (int i = 0; i < 40 && (tg_req || !empty); i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("drain_done", {30'd0, tg_req, empty}, 32'h1);
    $display("model drops so far=%0d", m_drops);

    // Ordering/wrap: 20 writes, tg_ack toggling every cycle
    rec = 1'b1;
    xfer_q.delete();
    exp_q.delete();
    ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      d = 16'($urandom);
      exp_q.push_back({a, d});
      step(1'b1, a, d, ack, 1'b0);
      ack = ~ack;
      step(1'b0, 16'h0, 16'h0, ack, 1'b0);
      ack = ~ack;
    end
    for (int i = 0; i < 40 && (tg_req || !empty); i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    rec = 1'b0;
    chk("order_count", 32'(xfer_q.size()), 32'd20);
    chk("order_ovf",   32'(ovf),           32'd0);
    for (int i = 0; i < 20 && i < xfer_q.size(); i++) chk("order_entry", xfer_q[i], exp_q[i]);

    // Reset while a request is outstanding and three entries are queued
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0200 + i), 16'(16'h0300 + i), 1'b0, 1'b0);
    chk("midreq_lvl", 32'(level),  32'd3);
    chk("midreq_req", 32'(tg_req), 32'd1);
    @(negedge clk);
    wa_wr_s = 1'b0;
    tg_ack  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   32'(tg_req), 32'd0);
    chk("async_level", 32'(level),  32'd0);
    chk("async_empty", 32'(empty),  32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("post_rst_noreq", 32'(tg_req), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
